// File: rtl/otter_mdu_pkg.sv
// Shared definitions for the OTTER multi-cycle ALU / multiply-divide unit.
// Contents:
//   alu_op_t  - 5-bit operation codes (single-cycle ALU ops plus RV32M ops)
//   state_t   - controller states
//   is_mul / is_div / is_signed_a / is_signed_b - op classification helpers
package otter_mdu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SLL    = 5'd1,
    OP_SLT    = 5'd2,
    OP_SLTU   = 5'd3,
    OP_XOR    = 5'd4,
    OP_SRL    = 5'd5,
    OP_OR     = 5'd6,
    OP_AND    = 5'd7,
    OP_SUB    = 5'd8,
    OP_LUI    = 5'd9,
    OP_SRA    = 5'd13,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Operand A is two's complement for MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is two's complement for MULH, DIV and REM (MULHSU treats B as unsigned).
  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/otter_alu_core.sv
// Combinational single-cycle OTTER ALU.
// Ports:
//   i_op     - operation code (alu_op_t values 0-13; anything else yields 0)
//   i_a, i_b - operands; shifts use i_b[SHW-1:0] as the shift amount
//   o_result - combinational result
module otter_alu_core
  import otter_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  // NOTE: assigning a default before the case keeps this block purely
  // combinational; a path that leaves o_result unassigned would infer a latch.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SRL:  o_result = i_a >> w_shamt;
      OP_SLL:  o_result = i_a << w_shamt;
      OP_SRA:  o_result = $signed(i_a) >>> w_shamt;
      OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, i_a < i_b};
      OP_LUI:  o_result = i_a;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/otter_mdu_alu.sv
// OTTER EX-stage ALU with iterative RV32M multiply (shift-add) and divide
// (restoring), one bit per cycle, behind valid/ready handshakes.
// Ports:
//   CLK, RST_N          - clock, asynchronous active-low reset
//   in_valid / in_ready - operation handshake (in_ready only in IDLE)
//   op, a, b            - operation code and operands
//   flush               - abort the in-flight operation (no effect in IDLE)
//   out_valid/out_ready - result handshake; result held while stalled
//   result              - registered result
//   busy                - controller not in IDLE
module otter_mdu_alu
  import otter_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_result;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier, r_rem, r_quo, r_dvsr;
  logic [SHW-1:0]     r_cnt;
  logic               r_neg;  // final result must be negated
  logic               r_hi;   // MUL-class: take high half; DIV-class: take remainder

  // ---------------- accept-time decode ----------------
  logic             w_accept, w_sa, w_sb, w_is_rem, w_special;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_special_res, w_core_res;

  assign w_accept = in_valid && in_ready;
  assign w_sa     = is_signed_a(op) && a[WIDTH-1];
  assign w_sb     = is_signed_b(op) && b[WIDTH-1];
  assign w_mag_a  = w_sa ? -a : a;
  assign w_mag_b  = w_sb ? -b : b;
  assign w_is_rem = (op == OP_REM) || (op == OP_REMU);

  // Divide by zero and signed overflow bypass the iteration entirely.
  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (is_div(op)) begin
      if (b == '0) begin
        w_special     = 1'b1;
        w_special_res = w_is_rem ? a : '1;
      end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1)) begin
        w_special     = 1'b1;
        w_special_res = (op == OP_DIV) ? MIN_VAL : '0;
      end
    end
  end

  otter_alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_result (w_core_res)
  );

  // ---------------- iteration step logic ----------------
  logic [2*WIDTH-1:0] w_acc_step, w_prod;
  logic [WIDTH-1:0]   w_mul_res;
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod     = r_neg ? -w_acc_step : w_acc_step;
  assign w_mul_res  = r_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];

  // Partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits and a successful trial difference fits in WIDTH bits.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub, w_rem_step, w_quo_step, w_div_mag, w_div_res;
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = w_shift >= {1'b0, r_dvsr};
  assign w_sub      = w_shift[WIDTH-1:0] - r_dvsr;
  assign w_rem_step = w_ge ? w_sub : w_shift[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};
  assign w_div_mag  = r_hi ? w_rem_step : w_quo_step;
  assign w_div_res  = r_neg ? -w_div_mag : w_div_mag;

  // ---------------- controller ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) begin
          if (is_mul(op))                   w_state_next = MUL;
          else if (is_div(op) && !w_special) w_state_next = DIV;
          else                              w_state_next = DONE;
        end
      end
      MUL, DIV: begin
        if (flush)              w_state_next = IDLE;
        else if (r_cnt == '0)   w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  // NOTE: every datapath register is cleared on reset, so an operation
  // interrupted by reset leaves nothing behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_result <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (is_mul(op)) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_cnt    <= SHW'(WIDTH-1);
            r_neg    <= w_sa ^ w_sb;
            r_hi     <= (op != OP_MUL);
          end else if (is_div(op) && !w_special) begin
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_dvsr   <= w_mag_b;
            r_cnt    <= SHW'(WIDTH-1);
            // Quotient sign is the XOR of operand signs; remainder follows the dividend.
            r_neg    <= w_is_rem ? w_sa : (w_sa ^ w_sb);
            r_hi     <= w_is_rem;
          end else begin
            r_result <= w_special ? w_special_res : w_core_res;
          end
        end
        MUL: if (!flush) begin
          r_acc    <= w_acc_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == '0) r_result <= w_mul_res;
        end
        DIV: if (!flush) begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_result <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
